// File: rtl/llr_frame_loader.sv
// llr_frame_loader: ping-pong loader assembling saturated channel LLRs into decoder frames
module llr_frame_loader #(
  parameter int data_w = 8,
  parameter int in_w   = 12,
  parameter int R      = 24,
  parameter int D      = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [in_w-1:0]         in_llr,
  output logic [R*D*data_w-1:0]   frame,
  output logic                    frame_valid,
  input  logic                    frame_take,
  output logic                    sat
);
  localparam int N  = R * D;
  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);
  localparam logic [data_w-1:0] POS = {1'b0, {(data_w-1){1'b1}}};
  localparam logic [data_w-1:0] NEG = {1'b1, {(data_w-2){1'b0}}, 1'b1};
  localparam logic signed [in_w-1:0] MAXV = in_w'(POS);
  localparam logic signed [in_w-1:0] MINV = -MAXV;

  logic [N*data_w-1:0] bank0_q, bank1_q;
  logic [1:0]          full_q, full_d;
  logic                wr_q, wr_d, rd_q, rd_d, sat_q, sat_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic                acc, take, last, hi, lo;
  logic [data_w-1:0]   wdat;

  assign in_ready    = !full_q[wr_q];
  assign frame_valid = full_q[rd_q];
  assign frame       = rd_q ? bank1_q : bank0_q;
  assign sat         = sat_q;

  // Handshakes and symmetric clipping of the incoming sample
  always_comb begin
    acc  = in_valid && in_ready;
    take = frame_take && frame_valid;
    last = idx_q == LAST;
    hi   = $signed(in_llr) > MAXV;
    lo   = $signed(in_llr) < MINV;
    wdat = hi ? POS : lo ? NEG : in_llr[data_w-1:0];
  end

  // Next-state for pointers, full flags and sticky clip flag
  always_comb begin
    full_d = full_q;
    if (take) full_d[rd_q] = 1'b0;
    if (acc && last) full_d[wr_q] = 1'b1;
    idx_d = acc ? (last ? '0 : idx_q + 1'b1) : idx_q;
    wr_d  = wr_q ^ (acc && last);
    rd_d  = rd_q ^ take;
    sat_d = sat_q | (acc && (hi || lo));
  end

  // Control state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= '0;
      idx_q  <= '0;
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
      sat_q  <= 1'b0;
    end else begin
      full_q <= full_d;
      idx_q  <= idx_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      sat_q  <= sat_d;
    end
  end

  // Slot write into the bank currently being filled; stale data is simply overwritten
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank0_q <= '0;
      bank1_q <= '0;
    end else if (acc) begin
      if (wr_q) bank1_q[idx_q*data_w +: data_w] <= wdat;
      else bank0_q[idx_q*data_w +: data_w] <= wdat;
    end
  end
endmodule

// File: tb/tb_llr_frame_loader.sv
// tb_llr_frame_loader: scoreboard bench for the ping-pong LLR frame loader
module tb_llr_frame_loader;
  localparam int N = 576;
  logic clk = 0, rst = 1, in_valid = 0, frame_take = 0;
  logic [11:0] in_llr = '0;
  logic in_ready, frame_valid, sat;
  logic [N*8-1:0] frame;
  int n_err = 0, n_chk = 0, stalls = 0;
  logic [7:0] exp_q[$];

  llr_frame_loader dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_llr(in_llr),
    .frame(frame), .frame_valid(frame_valid), .frame_take(frame_take), .sat(sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] sat_model(input int v);
    int c;
    c = v > 127 ? 127 : v < -127 ? -127 : v;
    return c[7:0];
  endfunction

  task automatic send(input int v);
    int w;
    w = 0;
    in_valid = 1;
    in_llr = v[11:0];
    while (!in_ready && w < 100) begin
      @(posedge clk); #1;
      w++;
      stalls++;
    end
    if (!in_ready) check("send_timeout", 0, 1);
    else begin
      exp_q.push_back(sat_model(v));
      @(posedge clk); #1;
    end
    in_valid = 0;
  endtask

  task automatic check_frame(input string tag);
    logic [7:0] e;
    for (int i = 0; i < N; i++) begin
      if (exp_q.size() == 0) begin
        check({tag, "_sb_empty"}, 0, 1);
        break;
      end
      e = exp_q.pop_front();
      check($sformatf("%s_slot%0d", tag, i), frame[i*8 +: 8], e);
    end
  endtask

  task automatic take;
    frame_take = 1;
    @(posedge clk); #1;
    frame_take = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(posedge clk); #1;
    check("rst_ready", in_ready, 1);
    check("rst_fvalid", frame_valid, 0);
    check("rst_frame_zero", frame == '0, 1);
    check("rst_sat", sat, 0);

    stalls = 0;
    for (int k = 0; k < N - 1; k++) send(k % 100);
    check("fill_before_last", frame_valid, 0);
    send((N - 1) % 100);
    check("fill_fvalid", frame_valid, 1);
    check("fill_ready", in_ready, 1);
    check("fill_stalls", stalls, 0);
    check("fill_sat", sat, 0);
    check_frame("f0");
    take();
    check("take_fvalid", frame_valid, 0);

    send(300);
    check("sat_first", sat, 1);
    send(-300);
    send(-128);
    send(127);
    for (int k = 4; k < N; k++) send(k % 50);
    check("sat_sticky", sat, 1);
    check_frame("fsat");
    take();

    for (int k = 0; k < 2 * N; k++) send($urandom_range(0, 254) - 127);
    check("both_full_ready", in_ready, 0);
    check("both_full_fvalid", frame_valid, 1);
    in_valid = 1;
    in_llr = 12'd99;
    repeat (3) @(posedge clk);
    #1 check("ignored_ready", in_ready, 0);
    in_valid = 0;
    check_frame("fa");
    take();
    check("after_take_ready", in_ready, 1);
    check("after_take_fvalid", frame_valid, 1);
    check_frame("fb");
    take();
    check("drained_fvalid", frame_valid, 0);

    for (int k = 0; k < N; k++) send((k * 7) % 128 - 64);
    check_frame("p0");
    for (int k = 0; k < N - 1; k++) send((k * 3) % 200 - 100);
    frame_take = 1;
    send(42);
    frame_take = 0;
    check("overlap_fvalid", frame_valid, 1);
    check("overlap_ready", in_ready, 1);
    check_frame("p1");
    take();

    for (int k = 0; k < 300; k++) send(k % 100);
    exp_q.delete();
    #2 rst = 1;
    #1 check("inrst_fvalid", frame_valid, 0);
    check("inrst_ready", in_ready, 1);
    check("inrst_frame_zero", frame == '0, 1);
    @(posedge clk); #1 rst = 0;
    check("postrst_sat", sat, 0);
    for (int k = 0; k < N - 1; k++) send(5);
    check("rstfill_before_last", frame_valid, 0);
    send(5);
    check("rstfill_fvalid", frame_valid, 1);
    check_frame("r5");
    take();
    check("final_fvalid", frame_valid, 0);
    check("sb_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
